// File: rtl/putbits_pkg.sv
// Shared constants and helpers for the MPEG bit writer (putbits) and reader (flushbuffer).
package putbits_pkg;

  localparam int MAX_CODE_BITS = 32;

  typedef logic [5:0] code_len_t;

  function automatic int unsigned roundup8(input int unsigned x);
    return (x + 32'd7) & ~32'd7;
  endfunction

endpackage

// File: rtl/putbits_ins.sv
// Mask-and-shift of a variable-length code into its MSB-aligned slot in the accumulator.
module putbits_ins
  import putbits_pkg::*;
#(
  parameter int ACC_BITS = 64,
  parameter int CW       = 7
) (
  input  logic [31:0]         val,
  input  code_len_t           len,
  input  logic [CW-1:0]       pos,
  output logic [ACC_BITS-1:0] ins
);

  logic [32:0]         mask;
  logic [ACC_BITS-1:0] ext;

  // Left-justify the masked code, then slide it down to the fill point.
  always_comb begin
    mask = (33'd1 << len) - 33'd1;
    ext  = {val & mask[31:0], {(ACC_BITS-MAX_CODE_BITS){1'b0}}};
    ins  = (ext << (6'd32 - len)) >> pos;
  end

endmodule

// File: rtl/putbits.sv
// MPEG bitstream writer: packs 1..32-bit codes MSB first and drains whole bytes.
// Optional PUTBITS_BITCOUNT_EN enables the running bit_total counter.
module putbits
  import putbits_pkg::*;
#(
  parameter int ACC_BITS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] val,
  input  logic [5:0]  n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        align,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        empty,
  output logic [31:0] bit_total
);

  localparam int CW = $clog2(ACC_BITS + 1);
  localparam logic [CW-1:0] READY_MAX = CW'(ACC_BITS - MAX_CODE_BITS);

  logic [ACC_BITS-1:0] acc, acc_next, acc_sum, ins;
  logic [CW-1:0]       cnt, cnt_next;
  code_len_t           n_eff;
  logic                code_acc, align_acc, drain;
  int unsigned         fill;

  assign n_eff     = (n > 6'(MAX_CODE_BITS)) ? 6'(MAX_CODE_BITS) : n;
  assign in_ready  = (cnt <= READY_MAX);
  assign out_valid = (cnt >= CW'(8));
  assign out_byte  = acc[ACC_BITS-1 -: 8];
  assign empty     = (cnt == '0);

  putbits_ins #(.ACC_BITS(ACC_BITS), .CW(CW)) u_ins (
    .val (val),
    .len (n_eff),
    .pos (cnt),
    .ins (ins)
  );

  // Insert at the pre-drain fill point; the drained byte is already complete when cnt >= 8.
  // NOTE: every always_comb output gets an unconditional assignment first, so no latch can form.
  always_comb begin
    code_acc  = in_valid & in_ready;
    align_acc = align & in_ready;
    drain     = out_valid & out_ready;
    fill      = 32'(cnt) + (code_acc ? 32'(n_eff) : 32'd0);
    if (align_acc) fill = roundup8(fill);
    acc_sum   = code_acc ? (acc | ins) : acc;
    acc_next  = drain ? (acc_sum << 8) : acc_sum;
    cnt_next  = drain ? CW'(fill - 32'd8) : CW'(fill);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

`ifdef PUTBITS_BITCOUNT_EN
  logic [31:0] bit_cnt;

  // Code bits plus alignment padding; wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bit_cnt <= '0;
    else      bit_cnt <= bit_cnt + (fill - 32'(cnt));
  end

  assign bit_total = bit_cnt;
`else
  assign bit_total = '0;
`endif

endmodule

// File: tb/tb_putbits.sv
// Directed self-checking bench for putbits; expectations are hand-computed per scenario.
module tb_putbits;

`ifdef PUTBITS_BITCOUNT_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] val = '0;
  logic [5:0]  n = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        align = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        empty;
  logic [31:0] bit_total;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_bits = '0;

  putbits #(.ACC_BITS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .val       (val),
    .n         (n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .align     (align),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .empty     (empty),
    .bit_total (bit_total)
  );

  always #5 clk = ~clk;

  task automatic chk_bits(input string name);
    logic [31:0] want;
    want = BC_EN ? exp_bits : 32'd0;
    total++;
    if (bit_total !== want) begin
      bad++;
      $display("FAIL %s bit_total got=%0d want=%0d", name, bit_total, want);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_byte, empty} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL reset_outputs got ir=%b ov=%b ob=%h em=%b want ir=1 ov=0 ob=00 em=1",
               in_ready, out_valid, out_byte, empty);
    end
    chk_bits("reset");
    rst = 1'b1;
  endtask

  task automatic test_pack();
    out_ready = 1'b1;
    val = 32'h5; n = 6'd3; in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL pack_partial out_valid got=%b want=0", out_valid); end
    val = 32'h1F; n = 6'd5;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_byte !== 8'hBF) begin
      bad++; $display("FAIL pack_byte got ov=%b ob=%h want ov=1 ob=bf", out_valid, out_byte);
    end
    @(negedge clk);
    total++;
    if (empty !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL pack_empty got em=%b ov=%b want em=1 ov=0", empty, out_valid);
    end
    exp_bits += 32'd8;
    chk_bits("pack");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    out_ready = 1'b1;
    val = 32'hDEADBEEF; n = 6'd32; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_byte !== exp_b[i]) begin
        bad++; $display("FAIL b2b_byte%0d got ov=%b ob=%h want ov=1 ob=%h", i, out_valid, out_byte, exp_b[i]);
      end
    end
    @(negedge clk);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", empty); end
    exp_bits += 32'd32;
    chk_bits("b2b");
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_b [12];
    int acc_idx;
    bit pend;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    acc_idx = -1;
    pend = 1'b0;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready0 got=%b want=1", in_ready); end
    val = 32'h11223344; n = 6'd32; in_valid = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready32 got=%b want=1", in_ready); end
    val = 32'h55667788;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
    val = 32'h99AABBCC;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_byte !== 8'h11) begin
      bad++; $display("FAIL bp_hold got ir=%b ov=%b ob=%h want ir=0 ov=1 ob=11", in_ready, out_valid, out_byte);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (pend) begin in_valid = 1'b0; pend = 1'b0; end
      total++;
      if (out_valid !== 1'b1 || out_byte !== exp_b[i]) begin
        bad++; $display("FAIL bp_byte%0d got ov=%b ob=%h want ov=1 ob=%h", i, out_valid, out_byte, exp_b[i]);
      end
      if (in_valid && in_ready) begin acc_idx = i; pend = 1'b1; end
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (acc_idx != 4 || empty !== 1'b1) begin
      bad++; $display("FAIL bp_third got accept_at=%0d em=%b want accept_at=4 em=1", acc_idx, empty);
    end
    exp_bits += 32'd96;
    chk_bits("bp");
  endtask

  task automatic test_align();
    out_ready = 1'b1;
    val = 32'h3; n = 6'd2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; align = 1'b1;
    @(negedge clk);
    align = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_byte !== 8'hC0) begin
      bad++; $display("FAIL align_byte got ov=%b ob=%h want ov=1 ob=c0", out_valid, out_byte);
    end
    @(negedge clk);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL align_empty got=%b want=1", empty); end
    exp_bits += 32'd8;
    chk_bits("align");
  endtask

  task automatic test_len_edges();
    out_ready = 1'b0;
    val = 32'hFFFFFFFA; n = 6'd4; in_valid = 1'b1;
    @(negedge clk);
    val = 32'h12345678; n = 6'd0;
    total++;
    if (empty !== 1'b0) begin bad++; $display("FAIL nib_held got em=%b want=0", empty); end
    @(negedge clk);
    total++;
    if (empty !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL n0_noop got em=%b ov=%b want em=0 ov=0", empty, out_valid);
    end
    val = 32'hFFFFFFF5; n = 6'd4;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_byte !== 8'hA5) begin
      bad++; $display("FAIL mask_byte got ov=%b ob=%h want ov=1 ob=a5", out_valid, out_byte);
    end
    out_ready = 1'b1;
    @(negedge clk);
    val = 32'hFFFFFFFF; n = 6'd40; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_byte !== 8'hFF) begin
        bad++; $display("FAIL sat_byte%0d got ov=%b ob=%h want ov=1 ob=ff", i, out_valid, out_byte);
      end
    end
    @(negedge clk);
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL sat_empty got=%b want=1", empty); end
    exp_bits += 32'd40;
    chk_bits("len_edges");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    val = 32'h000ABCDE; n = 6'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_byte !== 8'hAB) begin
      bad++; $display("FAIL mid_pre got ov=%b ob=%h want ov=1 ob=ab", out_valid, out_byte);
    end
    #2 rst = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_byte, empty} !== {1'b1, 1'b0, 8'h00, 1'b1}) begin
      bad++; $display("FAIL mid_async got ir=%b ov=%b ob=%h em=%b want ir=1 ov=0 ob=00 em=1",
                      in_ready, out_valid, out_byte, empty);
    end
    exp_bits = '0;
    chk_bits("mid_async");
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || empty !== 1'b1) begin
        bad++; $display("FAIL mid_stale%0d got ov=%b em=%b want ov=0 em=1", i, out_valid, empty);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_back_to_back();
    test_backpressure();
    test_align();
    test_len_edges();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
